// File: rtl/req_wbp_pkg.sv
// req_wbp_pkg: FSM state type and data-width helpers shared by the req_wbp_bridge slice.
package req_wbp_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int ADDR_W = 32;
    function automatic int lanes(input int dw);
        return dw / 8;
    endfunction
    function automatic int word_shift(input int dw);
        return $clog2(dw / 8);
    endfunction
endpackage

// File: rtl/req_wbp_bridge_fifo.sv
// fifo: single-clock FIFO with occupancy count; pushes when full and pops when empty are dropped.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign empty   = count == '0;
    assign do_push = push && count != (PW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop) rp <= rp + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/req_wbp_bridge.sv
// req_wbp_bridge: burst requests to a Wishbone B4 pipelined master with write/read data FIFOs.
// Define REQ_WBP_ERR_EN to let wb_err_i complete beats and report read_err/resp_err.
module req_wbp_bridge
    import req_wbp_pkg::*;
#(
    parameter int DW         = 32,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_OUT    = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic                            req_wrap,
    input  logic [LEN_W-1:0]                req_len,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [lanes(DW)-1:0]            req_mask,
    input  logic                            write_valid,
    input  logic [DW-1:0]                   write_data,
    output logic                            read_valid,
    output logic [DW-1:0]                   read_data,
    output logic                            read_err,
    input  logic                            read_ack,
    output logic                            resp_done,
    output logic                            resp_err,
    output logic                            wb_cyc_o,
    output logic                            wb_stb_o,
    input  logic                            wb_stall_i,
    input  logic                            wb_ack_i,
    input  logic                            wb_err_i,
    output logic                            wb_we_o,
    output logic [lanes(DW)-1:0]            wb_sel_o,
    output logic [ADDR_W-word_shift(DW)-1:0] wb_adr_o,
    output logic [DW-1:0]                   wb_dat_o,
    input  logic [DW-1:0]                   wb_dat_i
);
    localparam int WS = word_shift(DW);
    localparam int AW = ADDR_W - WS;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);
`ifdef REQ_WBP_ERR_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif
    state_t         state;
    logic [LEN_W:0] len_r, cnt_iss, cnt_cmp, cnt_cmp_nxt, outstanding;
    logic           wrap_r, err_r, cyc_r;
    logic           issue, cmp, done, beat_err;
    logic [AW-1:0]  adr_inc, adr_mask, adr_nxt;
    logic           w_empty, r_empty;
    logic [DW-1:0]  w_dout;
    logic [RW-1:0]  r_din, r_dout;
    logic [CW-1:0]  r_count, r_free, w_count_unused;
    logic           unused_bits;
`ifdef REQ_WBP_ERR_EN
    assign beat_err = wb_err_i;
    assign r_din    = {wb_err_i, wb_dat_i};
    assign read_err = r_dout[DW];
`else
    assign beat_err = 1'b0;
    assign r_din    = wb_dat_i;
    assign read_err = 1'b0;
`endif
    assign unused_bits = ^{req_addr[WS-1:0], w_count_unused, wb_err_i};
    assign outstanding = cnt_iss - cnt_cmp;
    assign r_free      = CW'(FIFO_DEPTH) - r_count;
    // A read beat may only issue if its data is guaranteed a free read-FIFO slot.
    assign wb_stb_o    = state == ISSUE && 32'(outstanding) < MAX_OUT &&
                         (wb_we_o ? !w_empty : 32'(r_free) > 32'(outstanding));
    assign issue       = wb_stb_o && !wb_stall_i;
    assign cmp         = (wb_ack_i || beat_err) && outstanding != '0;
    assign cnt_cmp_nxt = cnt_cmp + (cmp ? ONE : '0);
    assign done        = state == DRAIN && cnt_cmp_nxt == len_r;
    assign wb_cyc_o    = cyc_r || wb_stb_o;
    assign wb_dat_o    = w_dout;
    assign read_valid  = !r_empty;
    assign read_data   = r_dout[DW-1:0];
    assign adr_inc     = wb_adr_o + AW'(1);
    assign adr_mask    = AW'(len_r - ONE);
    assign adr_nxt     = wrap_r ? (wb_adr_o & ~adr_mask) | (adr_inc & adr_mask) : adr_inc;
    fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (write_valid),
        .din   (write_data),
        .pop   (issue && wb_we_o),
        .dout  (w_dout),
        .empty (w_empty),
        .count (w_count_unused)
    );
    fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_rfifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (cmp && !wb_we_o),
        .din   (r_din),
        .pop   (read_ack && read_valid),
        .dout  (r_dout),
        .empty (r_empty),
        .count (r_count)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_adr_o  <= '0;
            len_r     <= '0;
            wrap_r    <= 1'b0;
            cnt_iss   <= '0;
            cnt_cmp   <= '0;
            cyc_r     <= 1'b0;
            err_r     <= 1'b0;
            resp_done <= 1'b0;
            resp_err  <= 1'b0;
        end else begin
            resp_done <= 1'b0;
            resp_err  <= 1'b0;
            if (issue) begin
                wb_adr_o <= adr_nxt;
                cnt_iss  <= cnt_iss + ONE;
                cyc_r    <= 1'b1;
            end
            if (cmp) begin
                cnt_cmp <= cnt_cmp_nxt;
                err_r   <= err_r | beat_err;
            end
            case (state)
                IDLE: begin
                    req_ready <= !(req_valid && req_ready);
                    if (req_valid && req_ready) begin
                        state    <= ISSUE;
                        wb_we_o  <= req_we;
                        wb_sel_o <= req_mask;
                        wb_adr_o <= req_addr[ADDR_W-1:WS];
                        len_r    <= req_len == '0 ? ONE : {1'b0, req_len};
                        wrap_r   <= req_wrap;
                        cnt_iss  <= '0;
                        cnt_cmp  <= '0;
                        err_r    <= 1'b0;
                    end
                end
                ISSUE: if (issue && cnt_iss + ONE == len_r) state <= DRAIN;
                DRAIN: begin
                    if (done) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        cyc_r     <= 1'b0;
                        resp_done <= 1'b1;
                        resp_err  <= err_r | (cmp & beat_err);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_req_wbp_bridge.sv
// tb_req_wbp_bridge: scoreboard bench for req_wbp_bridge; define REQ_WBP_ERR_EN to cover error beats.
module tb_req_wbp_bridge;
    localparam int DW = 32, LEN_W = 4, DEPTH = 4, MAX_OUT = 4;
`ifdef REQ_WBP_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    typedef struct {
        int          t;
        logic [31:0] adr;
        bit          err;
    } due_t;

    logic             clk_i = 0, rst_ni = 0;
    logic             req_valid = 0, req_we = 0, req_wrap = 0, write_valid = 0, read_ack = 0;
    logic [LEN_W-1:0] req_len = 0;
    logic [31:0]      req_addr = 0;
    logic [3:0]       req_mask = 0;
    logic [DW-1:0]    write_data = 0, wb_dat_i = 0;
    logic             wb_stall_i = 0, wb_ack_i = 0, wb_err_i = 0;
    logic             req_ready, read_valid, read_err, resp_done, resp_err;
    logic             wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]       wb_sel_o;
    logic [29:0]      wb_adr_o;
    logic [DW-1:0]    read_data, wb_dat_o;

    always #5 clk_i = ~clk_i;

    req_wbp_bridge #(.DW(DW), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wrap(req_wrap),
        .req_len(req_len), .req_addr(req_addr), .req_mask(req_mask),
        .write_valid(write_valid), .write_data(write_data),
        .read_valid(read_valid), .read_data(read_data), .read_err(read_err), .read_ack(read_ack),
        .resp_done(resp_done), .resp_err(resp_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i)
    );

    int          n_chk, n_pass, cyc_n, issued, completed, base_iss, done_cnt, exp_done, wavail;
    int          lat = 1, stall_pct = 0, err_beat = -1, last_iss;
    bit          rd_en = 1, stray, consec, hit_limit;
    due_t        due_q[$];
    logic [31:0] exp_adr_q[$], exp_wd_q[$];
    logic [32:0] exp_rd_q[$];
    bit          done_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rdat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a * 32'h101);
    endfunction

    // Slave model, scoreboard consumer and protocol checks, all on the falling edge.
    always @(negedge clk_i) begin
        due_t        d;
        logic [31:0] a;
        logic [32:0] r;
        int          out_b;
        cyc_n++;
        wb_ack_i = 0;
        wb_err_i = 0;
        if (rst_ni) begin
            out_b = issued - completed;
            if (due_q.size() > 0 && due_q[0].t == cyc_n) begin
                d = due_q.pop_front();
                wb_dat_i = rdat(d.adr);
                wb_ack_i = !(ERR && d.err);
                wb_err_i = d.err;
                completed++;
                check("cyc_at_ack", wb_cyc_o, 1);
            end else if (stray) begin
                wb_ack_i = 1;
                stray = 0;
            end
            wb_stall_i = $urandom_range(99) < stall_pct;
            if (out_b >= MAX_OUT) begin
                hit_limit = 1;
                check("stb_at_limit", wb_stb_o, 0);
            end
            if (wb_stb_o && wb_we_o) check("stb_needs_data", wavail > 0, 1);
            if (write_valid) wavail++;
            if (wb_stb_o && !wb_stall_i) begin
                if (exp_adr_q.size() == 0) check("extra_issue", 1, 0);
                else begin
                    a = exp_adr_q.pop_front();
                    check("wb_adr", {2'b0, wb_adr_o}, a);
                    if (consec && issued > base_iss) check("consec_issue", cyc_n - last_iss, 1);
                end
                if (wb_we_o) begin
                    wavail--;
                    check("wb_sel", wb_sel_o, req_mask);
                    if (exp_wd_q.size() == 0) check("extra_wdat", 1, 0);
                    else check("wb_dat", wb_dat_o, exp_wd_q.pop_front());
                end
                due_q.push_back('{cyc_n + lat, {2'b0, wb_adr_o}, (issued - base_iss) == err_beat});
                issued++;
                last_iss = cyc_n;
            end
            read_ack = rd_en;
            if (read_valid && rd_en) begin
                if (exp_rd_q.size() == 0) check("extra_read", 1, 0);
                else begin
                    r = exp_rd_q.pop_front();
                    check("read_data", read_data, r[31:0]);
                    check("read_err", read_err, r[32]);
                end
            end
            if (resp_done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    check("resp_err", resp_err, done_q.pop_front());
                    check("done_outstanding", out_b, 0);
                    check("done_unissued", exp_adr_q.size(), 0);
                end
                done_cnt++;
            end
        end
    end

    task automatic send(input bit we, input bit wrap, input int len, input logic [31:0] addr,
                        input logic [3:0] mask);
        int          n = (len == 0) ? 1 : len;
        logic [31:0] b = addr >> 2;
        logic [31:0] a;
        bit          ok = 0;
        base_iss = issued;
        for (int i = 0; i < n; i++) begin
            a = wrap ? ((b & ~(n - 1)) | ((b + i) & (n - 1))) : b + i;
            exp_adr_q.push_back(a);
            if (!we) exp_rd_q.push_back({ERR && i == err_beat, rdat(a)});
        end
        done_q.push_back(!we && ERR && err_beat >= 0 && err_beat < n);
        exp_done++;
        @(posedge clk_i);
        #1;
        req_valid = 1;
        req_we = we;
        req_wrap = wrap;
        req_len = len[LEN_W-1:0];
        req_addr = addr;
        req_mask = mask;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk_i);
            ok = req_ready;
        end
        check("req_accepted", ok, 1);
        @(posedge clk_i);
        #1 req_valid = 0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt < exp_done && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check("done_in_time", done_cnt, exp_done);
        @(posedge clk_i);
        #1;
        check("reads_drained", exp_rd_q.size(), 0);
    endtask

    task automatic push_wr(input logic [31:0] d);
        write_valid = 1;
        write_data = d;
        exp_wd_q.push_back(d);
        @(posedge clk_i);
        #1 write_valid = 0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk_i);
        check("rst_req_ready", req_ready, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_done", {resp_done, resp_err}, 0);
        check("rst_read_valid", read_valid, 0);
        @(posedge clk_i);
        #1 rst_ni = 1;
        @(negedge clk_i);
        check("ready_before_clk", req_ready, 0);
        @(negedge clk_i);
        check("ready_after_clk", req_ready, 1);
        consec = 1;
        send(0, 0, 4, 32'h100, 4'hF);
        wait_done(100);
        consec = 0;
        send(0, 1, 4, 32'h108, 4'hF);
        wait_done(100);
        send(1, 0, 8, 32'h200, 4'b1010);
        for (int i = 0; i < 8; i++) push_wr(32'h1000_0000 + i * 32'h1111);
        wait_done(100);
        check("write_data_used", exp_wd_q.size(), 0);
        lat = 10;
        stall_pct = 30;
        hit_limit = 0;
        send(0, 0, 8, 32'h300, 4'hF);
        wait_done(400);
        check("limit_reached", hit_limit, 1);
        lat = 1;
        stall_pct = 0;
        rd_en = 0;
        send(0, 0, 8, 32'h400, 4'hF);
        repeat (20) @(posedge clk_i);
        #1;
        check("issued_at_full", issued - base_iss, DEPTH);
        rd_en = 1;
        wait_done(200);
        err_beat = 2;
        send(0, 0, 4, 32'h500, 4'hF);
        wait_done(100);
        err_beat = -1;
        send(0, 0, 0, 32'h600, 4'hF);
        wait_done(100);
        lat = 10;
        send(0, 0, 8, 32'h700, 4'hF);
        k = 0;
        while (issued - base_iss < 2 && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        check("mid_burst_started", issued - base_iss >= 2, 1);
        @(posedge clk_i);
        #2 rst_ni = 0;
        #1;
        check("abort_cyc", wb_cyc_o, 0);
        check("abort_stb", wb_stb_o, 0);
        check("abort_ready", req_ready, 0);
        due_q.delete();
        exp_adr_q.delete();
        exp_rd_q.delete();
        done_q.delete();
        issued = 0;
        completed = 0;
        base_iss = 0;
        wavail = 0;
        exp_done = done_cnt;
        lat = 1;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        @(negedge clk_i);
        check("ready_before_clk2", req_ready, 0);
        @(negedge clk_i);
        check("ready_after_clk2", req_ready, 1);
        stray = 1;
        repeat (4) @(negedge clk_i);
        check("stray_ack_read", read_valid, 0);
        check("stray_ack_cyc", wb_cyc_o, 0);
        check("no_done_after_abort", done_cnt, exp_done);
        send(0, 0, 2, 32'h800, 4'hF);
        wait_done(100);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
